// File: rtl/vregfile_if.sv
// Port bundle for the vector register file: read ports, byte-masked write port,
// scoreboard reservation/release and the bulk-clear handshake.
interface vregfile_if #(
    parameter int NUM_VREGS = 32,
    parameter int VLEN      = 128,
    parameter int NUM_RD    = 3
);
    localparam int AW = $clog2(NUM_VREGS);
    localparam int NB = VLEN / 8;

    logic [NUM_RD-1:0][AW-1:0]   rd_addr_i;
    logic [NUM_RD-1:0][VLEN-1:0] rd_data_o;
    logic [NUM_RD-1:0]           rd_busy_o;
    logic                        we_i;
    logic [AW-1:0]               wr_addr_i;
    logic [VLEN-1:0]             wr_data_i;
    logic [NB-1:0]               wr_be_i;
    logic                        wr_release_i;
    logic                        rsv_i;
    logic [AW-1:0]               rsv_addr_i;
    logic [NUM_VREGS-1:0]        busy_o;
    logic                        clear_i;
    logic                        ready_o;
    logic                        clear_done_o;

    modport master (
        output rd_addr_i, we_i, wr_addr_i, wr_data_i, wr_be_i, wr_release_i,
               rsv_i, rsv_addr_i, clear_i,
        input  rd_data_o, rd_busy_o, busy_o, ready_o, clear_done_o
    );

    modport slave (
        input  rd_addr_i, we_i, wr_addr_i, wr_data_i, wr_be_i, wr_release_i,
               rsv_i, rsv_addr_i, clear_i,
        output rd_data_o, rd_busy_o, busy_o, ready_o, clear_done_o
    );
endinterface

// File: rtl/vregfile.sv
// Vector register file: combinational multi-port read with optional write bypass,
// byte-masked write, pending-write scoreboard and a one-register-per-cycle clear sweep.
module vregfile #(
    parameter int NUM_VREGS = 32,
    parameter int VLEN      = 128,
    parameter int NUM_RD    = 3,
    parameter bit BYPASS    = 1'b1
) (
    input logic       clk,
    input logic       rst,
    vregfile_if.slave bus
);
    localparam int AW = $clog2(NUM_VREGS);
    localparam int NB = VLEN / 8;
    localparam logic [AW-1:0] LAST = AW'(NUM_VREGS - 1);

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t                      state, state_nxt;
    logic                        ready;
    logic                        wr_en;
    logic [AW-1:0]               cnt;
    logic                        done_q;
    logic [VLEN-1:0]             mem [NUM_VREGS];
    logic [NUM_VREGS-1:0]        busy, busy_nxt;
    logic [NUM_RD-1:0][VLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.clear_i) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (cnt == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en = bus.we_i & ready;

    // Sweep counter holds at LAST rather than wrapping; it is re-zeroed on the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == CLEAR) && (cnt == LAST);
            if (state == IDLE && bus.clear_i)      cnt <= '0;
            else if (state == CLEAR && cnt != LAST) cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the storage array is reset explicitly because the register file must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_VREGS; r++) mem[r] <= '0;
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be_i[b]) mem[bus.wr_addr_i][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
        end
    end

    // Release is applied before reserve so a new producer wins; clear overrides both.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && bus.wr_release_i) busy_nxt[bus.wr_addr_i]  = 1'b0;
        if (ready && bus.rsv_i)        busy_nxt[bus.rsv_addr_i] = 1'b1;
        if (ready && bus.clear_i)      busy_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = mem[bus.rd_addr_i[p]];
            rd_busy[p] = busy[bus.rd_addr_i[p]];
            if (BYPASS && wr_en && bus.wr_addr_i == bus.rd_addr_i[p]) begin
                for (int b = 0; b < NB; b++)
                    if (bus.wr_be_i[b]) rd_data[p][8*b +: 8] = bus.wr_data_i[8*b +: 8];
            end
        end
    end

    assign bus.rd_data_o    = rd_data;
    assign bus.rd_busy_o    = rd_busy;
    assign bus.busy_o       = busy;
    assign bus.ready_o      = ready;
    assign bus.clear_done_o = done_q;
endmodule

// File: tb/tb_vregfile.sv
// Directed self-checking bench: two 32x128 instances (bypass on/off) sharing stimulus,
// plus an 8x64 build for the small-configuration clear and byte-enable cases.
module tb_vregfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    vregfile_if #(.NUM_VREGS(32), .VLEN(128), .NUM_RD(3)) if_a ();
    vregfile_if #(.NUM_VREGS(32), .VLEN(128), .NUM_RD(3)) if_b ();
    vregfile_if #(.NUM_VREGS(8),  .VLEN(64),  .NUM_RD(2)) if_c ();

    vregfile #(.NUM_VREGS(32), .VLEN(128), .NUM_RD(3), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    vregfile #(.NUM_VREGS(32), .VLEN(128), .NUM_RD(3), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    vregfile #(.NUM_VREGS(8),  .VLEN(64),  .NUM_RD(2), .BYPASS(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_b.rd_addr_i    = if_a.rd_addr_i;
    assign if_b.we_i         = if_a.we_i;
    assign if_b.wr_addr_i    = if_a.wr_addr_i;
    assign if_b.wr_data_i    = if_a.wr_data_i;
    assign if_b.wr_be_i      = if_a.wr_be_i;
    assign if_b.wr_release_i = if_a.wr_release_i;
    assign if_b.rsv_i        = if_a.rsv_i;
    assign if_b.rsv_addr_i   = if_a.rsv_addr_i;
    assign if_b.clear_i      = if_a.clear_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        if_a.we_i = 1'b0; if_a.wr_release_i = 1'b0; if_a.rsv_i = 1'b0; if_a.clear_i = 1'b0;
        if_a.wr_be_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] v0_val;
        logic [7:0]   fill_byte;
        int           low, done_n, done_at;

        if_a.rd_addr_i = '0; if_a.wr_addr_i = '0; if_a.wr_data_i = '0; if_a.rsv_addr_i = '0;
        idle_a();
        if_c.rd_addr_i = '0; if_c.we_i = 1'b0; if_c.wr_addr_i = '0; if_c.wr_data_i = '0;
        if_c.wr_be_i = '0; if_c.wr_release_i = 1'b0; if_c.rsv_i = 1'b0; if_c.rsv_addr_i = '0;
        if_c.clear_i = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_rd_data", if_a.rd_data_o[0], 128'd0);
        check("rst_busy", 128'(if_a.busy_o), 128'd0);
        check("rst_rd_busy", 128'(if_a.rd_busy_o), 128'd0);
        check("rst_ready", 128'(if_a.ready_o), 128'd1);
        check("rst_done", 128'(if_a.clear_done_o), 128'd0);

        // Full write of v0, v1 untouched
        v0_val = 128'h0123456789ABCDEF0123456789ABCDEF;
        if_a.we_i = 1'b1; if_a.wr_addr_i = 5'd0; if_a.wr_data_i = v0_val; if_a.wr_be_i = '1;
        tick(); idle_a();
        if_a.rd_addr_i[0] = 5'd0; if_a.rd_addr_i[1] = 5'd1;
        #1;
        check("v0_write", if_a.rd_data_o[0], v0_val);
        check("v1_zero", if_a.rd_data_o[1], 128'd0);

        // Byte-masked write over v5, with and without bypass
        if_a.we_i = 1'b1; if_a.wr_addr_i = 5'd5; if_a.wr_data_i = {16{8'h55}}; if_a.wr_be_i = '1;
        tick();
        if_a.wr_data_i = {16{8'hAA}}; if_a.wr_be_i = 16'h00FF; if_a.rd_addr_i[2] = 5'd5;
        #1;
        check("v5_bypass", if_a.rd_data_o[2], 128'h5555555555555555AAAAAAAAAAAAAAAA);
        check("v5_nobypass", if_b.rd_data_o[2], {16{8'h55}});
        tick(); idle_a();
        #1;
        check("v5_merged_a", if_a.rd_data_o[2], 128'h5555555555555555AAAAAAAAAAAAAAAA);
        check("v5_merged_b", if_b.rd_data_o[2], 128'h5555555555555555AAAAAAAAAAAAAAAA);

        // Scoreboard on v7
        if_a.rsv_i = 1'b1; if_a.rsv_addr_i = 5'd7; if_a.rd_addr_i[0] = 5'd7;
        tick(); idle_a();
        check("v7_rsv", 128'(if_a.busy_o[7]), 128'd1);
        check("v7_rd_busy", 128'(if_a.rd_busy_o[0]), 128'd1);
        if_a.we_i = 1'b1; if_a.wr_addr_i = 5'd7; if_a.wr_be_i = '0; if_a.wr_data_i = '1;
        if_a.wr_release_i = 1'b1;
        tick(); idle_a();
        check("v7_release", 128'(if_a.busy_o[7]), 128'd0);
        check("v7_be0_nowrite", if_a.rd_data_o[0], 128'd0);
        if_a.we_i = 1'b1; if_a.wr_release_i = 1'b1; if_a.rsv_i = 1'b1;
        tick(); idle_a();
        check("v7_set_wins", 128'(if_a.busy_o[7]), 128'd1);

        // Fill every register non-zero, reserve v3
        for (int r = 0; r < 32; r++) begin
            fill_byte = 8'(r + 1);
            if_a.we_i = 1'b1; if_a.wr_addr_i = 5'(r); if_a.wr_data_i = {16{fill_byte}}; if_a.wr_be_i = '1;
            tick();
        end
        idle_a();
        if_a.rsv_i = 1'b1; if_a.rsv_addr_i = 5'd3; if_a.rd_addr_i[1] = 5'd31;
        tick(); idle_a();
        check("fill_v31", if_a.rd_data_o[1], {16{8'd32}});
        check("v3_rsv", 128'(if_a.busy_o[3]), 128'd1);

        // Bulk clear with write/reserve attempts during the sweep
        if_a.clear_i = 1'b1;
        tick();
        if_a.clear_i = 1'b0;
        check("clr_busy_t1", 128'(if_a.busy_o), 128'd0);
        low = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i <= 32) begin
                if_a.we_i = 1'b1; if_a.wr_addr_i = 5'd31; if_a.wr_data_i = '1; if_a.wr_be_i = '1;
                if_a.rsv_i = 1'b1; if_a.rsv_addr_i = 5'd2;
            end else begin
                idle_a();
            end
            #1;
            if (!if_a.ready_o) low++;
            if (if_a.clear_done_o) begin done_n++; done_at = i; end
            tick();
        end
        idle_a();
        check("clr_ready_low", 128'(low), 128'd32);
        check("clr_done_count", 128'(done_n), 128'd1);
        check("clr_done_cycle", 128'(done_at), 128'd33);
        check("clr_busy_end", 128'(if_a.busy_o), 128'd0);
        for (int r = 0; r < 32; r++) begin
            if_a.rd_addr_i[0] = 5'(r);
            #1;
            check($sformatf("clr_v%0d", r), if_a.rd_data_o[0], 128'd0);
        end
        check("clr_b_v5", if_b.rd_data_o[2], 128'd0);

        // Reset during a clear sweep
        if_a.we_i = 1'b1; if_a.wr_addr_i = 5'd10; if_a.wr_data_i = {16{8'h3C}}; if_a.wr_be_i = '1;
        if_a.rsv_i = 1'b1; if_a.rsv_addr_i = 5'd11;
        tick(); idle_a();
        check("pre_rst_busy11", 128'(if_a.busy_o[11]), 128'd1);
        if_a.clear_i = 1'b1;
        tick();
        if_a.clear_i = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        if_a.rd_addr_i[0] = 5'd10; if_a.rd_addr_i[1] = 5'd20;
        #1;
        check("rst_mid_ready", 128'(if_a.ready_o), 128'd1);
        check("rst_mid_busy", 128'(if_a.busy_o), 128'd0);
        check("rst_mid_v10", if_a.rd_data_o[0], 128'd0);
        check("rst_mid_v20", if_a.rd_data_o[1], 128'd0);
        tick();
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (if_a.clear_done_o) done_n++;
            tick();
        end
        check("rst_mid_no_done", 128'(done_n), 128'd0);
        check("rst_mid_ready_after", 128'(if_a.ready_o), 128'd1);

        // Small build: 8 lanes and an 8-cycle sweep
        if_c.we_i = 1'b1; if_c.wr_addr_i = 3'd2; if_c.wr_data_i = 64'h1122334455667788; if_c.wr_be_i = 8'hFF;
        tick();
        if_c.wr_data_i = 64'hAABBCCDDEEFF0011; if_c.wr_be_i = 8'hA5;
        tick();
        if_c.we_i = 1'b0; if_c.wr_be_i = '0; if_c.rd_addr_i[0] = 3'd2;
        #1;
        check("c_be_merge", 128'(if_c.rd_data_o[0]), 128'h0000000000000000AA22CC4455FF7711);
        if_c.clear_i = 1'b1;
        tick();
        if_c.clear_i = 1'b0;
        low = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 14; i++) begin
            if (!if_c.ready_o) low++;
            if (if_c.clear_done_o) begin done_n++; done_at = i; end
            tick();
        end
        check("c_clr_ready_low", 128'(low), 128'd8);
        check("c_clr_done_cycle", 128'(done_at), 128'd9);
        check("c_clr_done_count", 128'(done_n), 128'd1);
        check("c_clr_v2", 128'(if_c.rd_data_o[0]), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vregfile.md
# vregfile

Parametrised vector register file for the vector datapath: NUM_VREGS architectural registers of VLEN bits, NUM_RD combinational read ports, one byte-masked write port with optional same-cycle write-to-read bypass, a per-register pending-write scoreboard, and a sequenced bulk-clear engine. It sits between vector decode/issue (reads, reservations) and vector writeback (writes, releases), alongside the scalar register file. Unlike the scalar file, register 0 is an ordinary register (v0 holds the mask).

## Interface
- NUM_VREGS, 32, number of vector registers (power of two, ≥2); AW = $clog2(NUM_VREGS)
- VLEN, 128, register width in bits (multiple of 8); NB = VLEN/8 byte lanes
- NUM_RD, 3, read ports (vs1, vs2, vd-old for merge)
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr_i  in  NUM_RD×AW  read addresses
- rd_data_o  out  NUM_RD×VLEN  read data
- rd_busy_o  out  NUM_RD  scoreboard bit of each addressed register
- we_i  in  1  write enable
- wr_addr_i  in  AW  write address
- wr_data_i  in  VLEN  write data
- wr_be_i  in  NB  byte enables, bit b covers bits [8b+7:8b]
- wr_release_i  in  1  with we_i: clear scoreboard bit of wr_addr_i
- rsv_i  in  1  reserve (mark busy) rsv_addr_i
- rsv_addr_i  in  AW  register to reserve
- busy_o  out  NUM_VREGS  full scoreboard vector
- clear_i  in  1  start bulk clear (sampled only in IDLE)
- ready_o  out  1  1 = IDLE, writes/reservations accepted
- clear_done_o  out  1  one-cycle pulse on clear completion

## Operation
- Storage: NUM_VREGS×VLEN flops, all zero on reset.
- Read: rd_data_o[p] = reg[rd_addr_i[p]], combinational. If BYPASS=1, we_i=1, ready_o=1 and wr_addr_i = rd_addr_i[p]: bytes with wr_be_i set come from wr_data_i, others from storage.
- Write: on clock edge with we_i=1 and ready_o=1, bytes with wr_be_i set update; others hold. wr_be_i = 0 writes nothing but release still applies.
- Scoreboard: busy[r] set by rsv_i on r; cleared by we_i & wr_release_i on r. Same cycle set and clear of the same r: set wins (new producer). Reserve of already-busy register: stays 1. rd_busy_o[p] = busy[rd_addr_i[p]] from registered state (no bypass).
- FSM states IDLE, CLEAR.
  - IDLE: ready_o=1. clear_i=1 -> CLEAR next cycle; counter ← 0; whole busy vector ← 0 on the same edge.
  - CLEAR: ready_o=0; each cycle reg[counter] ← 0, counter++. we_i, rsv_i, wr_release_i, clear_i ignored. When counter = NUM_VREGS-1 the write completes, clear_done_o pulses on the following cycle, state -> IDLE.
  - clear_i together with we_i/rsv_i in IDLE: write and reservation are performed first on that edge; busy vector still ends 0, register later cleared by the sweep.
- Counter is AW bits, no wrap beyond NUM_VREGS-1.

## Timing
- Read latency 0 (combinational); write visible to non-bypassed reads the cycle after the edge.
- Scoreboard update visible on busy_o/rd_busy_o the cycle after the edge.
- Clear: clear_i accepted at edge T; ready_o=0 cycles T+1..T+NUM_VREGS; clear_done_o=1 and ready_o=1 at T+NUM_VREGS+1.
- Reset values: all registers 0, rd_data_o 0, busy_o 0, rd_busy_o 0, ready_o 1, clear_done_o 0, state IDLE, counter 0.
- rst asserted mid-clear: immediate IDLE, all registers and busy 0, no clear_done_o pulse.

## Test plan
- Reset, then write v0=0x0123…CDEF (VLEN=128) be=all ones -> next cycle rd_data_o[0] of v0 equals written value; v1 reads 0.
- Write v5 data=all 0xAA, be=16'h00FF over stored all 0x55 -> v5 = upper 8 bytes 0x55, lower 8 bytes 0xAA; with BYPASS=1 same-cycle read of v5 already shows merged value; BYPASS=0 shows old all 0x55.
- rsv_i v7 -> busy_o[7]=1 next cycle; write v7 with release -> busy_o[7]=0; same-cycle rsv v7 + release v7 -> busy_o[7] stays 1.
- Fill all registers non-zero, reserve v3, pulse clear_i -> ready_o low exactly 32 cycles, busy_o 0 from T+1, writes during CLEAR ignored, clear_done_o single pulse at T+33, all registers read 0.
- Assert rst at cycle 10 of a clear -> ready_o=1, clear_done_o never pulses, all registers 0.
- NUM_VREGS=8, VLEN=64, NUM_RD=2 build: clear takes 8 cycles, byte-enable over 8 lanes correct.
